// File: rtl/mem_responder_pkg.sv
// Shared types and defaults for the wait-stated byte memory responder.
// Holds the FSM encoding, default geometry and the wait counter width.
`timescale 1ns/1ps

package mem_responder_pkg;

  localparam int DEF_WAIT_CYCLES = 2;
  localparam int DEF_AW          = 8;
  localparam int DEF_DW          = 8;
  localparam int CNT_W           = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RWAIT = 2'd1,
    ST_WWAIT = 2'd2
  } state_t;

  // Wait states beyond 15 cannot be represented; the legal range is 0..15.
  function automatic logic [CNT_W-1:0] wait_load(input int unsigned w);
    return CNT_W'(w);
  endfunction

endpackage

// File: rtl/mem_array.sv
// Byte storage: synchronous write, synchronous registered read.
// Only the read register is reset; the array contents survive reset.
`timescale 1ns/1ps

module mem_array #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // rdata holds its value between reads, so writes never disturb it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/mem_responder.sv
// Multicycle-controller memory responder: accepts one read or write in IDLE,
// holds busy for WAIT_CYCLES+1 cycles, then pulses rvalid or wack.
`timescale 1ns/1ps

module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int WAIT_CYCLES = DEF_WAIT_CYCLES,
  parameter int AW          = DEF_AW,
  parameter int DW          = DEF_DW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          memread,
  input  logic          memwrite,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  output logic          rvalid,
  output logic          wack,
  output logic          busy,
  output logic          err
);

  // Handshake: a request is taken on any rising edge where the responder is
  // idle (busy=0) and memread or memwrite is high; write wins if both are.
  // Inputs are ignored while busy=1. Completion is a one-cycle rvalid (read,
  // rdata valid in the same cycle) or wack (write committed); the responder
  // is idle again in that cycle, so a new request can be taken immediately.

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [AW-1:0]     addr_q;
  logic [DW-1:0]     wdata_q;
  logic              rvalid_q, wack_q, err_q;

  logic              accept;
  logic              done;
  logic              do_rd;
  logic              do_wr;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (memwrite) begin
          state_d = ST_WWAIT;
        end else if (memread) begin
          state_d = ST_RWAIT;
        end
      end
      ST_RWAIT, ST_WWAIT: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output / control decode
  always_comb begin
    busy   = (state_q == ST_RWAIT) || (state_q == ST_WWAIT);
    accept = (state_q == ST_IDLE) && (memread || memwrite);
    done   = busy && (cnt_q == '0);
    do_rd  = done && (state_q == ST_RWAIT);
    do_wr  = done && (state_q == ST_WWAIT);
  end

  // Request capture and wait-state countdown
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      cnt_q   <= wait_load(WAIT_CYCLES);
      addr_q  <= addr;
      wdata_q <= wdata;
    end else if (busy && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  // Completion and error pulses, each valid for the cycle after its edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rvalid_q <= 1'b0;
      wack_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      rvalid_q <= do_rd;
      wack_q   <= do_wr;
      err_q    <= accept && memread && memwrite;
    end
  end

  assign rvalid = rvalid_q;
  assign wack   = wack_q;
  assign err    = err_q;

  mem_array #(
    .AW (AW),
    .DW (DW)
  ) u_mem (
    .clk   (clk),
    .reset (reset),
    .we    (do_wr),
    .waddr (addr_q),
    .wdata (wdata_q),
    .re    (do_rd),
    .raddr (addr_q),
    .rdata (rdata)
  );

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: scoreboarded reads, busy/pulse
// timing, error, ignore-while-busy, reset abort and a zero-wait instance.
`timescale 1ns/1ps

module tb_mem_responder;

  localparam int W = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       memread, memwrite;
  logic [7:0] addr, wdata;
  logic [7:0] rdata;
  logic       rvalid, wack, busy, err;

  logic       memread0, memwrite0;
  logic [7:0] addr0, wdata0;
  logic [7:0] rdata0;
  logic       rvalid0, wack0, busy0, err0;

  logic [7:0] exp_q[$];
  logic [7:0] model [0:255];
  logic [7:0] last_rd;
  int         vectors = 0;
  int         errors  = 0;
  int         wack_seen = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  mem_responder #(.WAIT_CYCLES(W), .AW(8), .DW(8)) dut (
    .clk(clk), .reset(rst), .memread(memread), .memwrite(memwrite),
    .addr(addr), .wdata(wdata), .rdata(rdata), .rvalid(rvalid),
    .wack(wack), .busy(busy), .err(err)
  );

  mem_responder #(.WAIT_CYCLES(0), .AW(8), .DW(8)) dut0 (
    .clk(clk), .reset(rst), .memread(memread0), .memwrite(memwrite0),
    .addr(addr0), .wdata(wdata0), .rdata(rdata0), .rvalid(rvalid0),
    .wack(wack0), .busy(busy0), .err(err0)
  );

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard: every rvalid pops the oldest expected read value.
  always @(negedge clk) begin
    logic [7:0] e;
    if (!rst) begin
      if (wack) wack_seen++;
      if (rvalid) begin
        if (exp_q.size() == 0) begin
          check("rvalid_spurious", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("rdata", {24'd0, rdata}, {24'd0, e});
        end
      end
    end
  end

  // ---------------- driver ----------------
  // Called at #1 after an edge with the DUT idle; returns at #1 after the
  // completing edge (the rvalid/wack cycle), so calls chain back-to-back.
  task automatic access(input logic wr, input logic rd, input logic [7:0] a,
                        input logic [7:0] d, input logic noise, input string tag);
    int n;
    memwrite = wr; memread = rd; addr = a; wdata = d;
    if (wr) begin
      model[a] = d;
    end else if (rd) begin
      exp_q.push_back(model[a]);
      last_rd = model[a];
    end
    @(posedge clk); #1;
    memwrite = 1'b0; memread = 1'b0;
    addr = 8'($urandom); wdata = 8'($urandom);
    check({tag, "/err"}, {31'd0, err}, {31'd0, wr & rd});
    check({tag, "/pulse_clr"}, {30'd0, rvalid, wack}, 32'd0);
    n = 0;
    while (busy && n < 40) begin
      if (noise) begin
        memread  = 1'($urandom_range(0, 1));
        memwrite = 1'($urandom_range(0, 1));
        addr     = 8'h30;
      end
      @(posedge clk); #1;
      n++;
    end
    memread = 1'b0; memwrite = 1'b0;
    check({tag, "/busy_len"}, n, W + 1);
    check({tag, "/wack"}, {31'd0, wack}, {31'd0, wr});
    check({tag, "/rvalid"}, {31'd0, rvalid}, {31'd0, rd & ~wr});
    if (wr) check({tag, "/rdata_hold"}, {24'd0, rdata}, {24'd0, last_rd});
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int ws;
    logic [7:0] a, d;
    rst = 1'b1; memread = 0; memwrite = 0; addr = 0; wdata = 0;
    memread0 = 0; memwrite0 = 0; addr0 = 0; wdata0 = 0;
    last_rd = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check("rst_outs", {rdata, rvalid, wack, busy, err}, 32'd0);
    rst = 1'b0;

    // Basic write/read, first request right after reset release.
    access(1, 0, 8'h10, 8'hA5, 0, "w10");
    access(0, 1, 8'h10, 8'h00, 0, "r10");

    // Simultaneous request: write wins, err pulses.
    access(1, 1, 8'h20, 8'h3C, 0, "rw20");
    access(0, 1, 8'h20, 8'h00, 0, "r20");

    // Requests toggled while busy are ignored.
    @(negedge clk); ws = wack_seen; #6;
    access(1, 0, 8'h31, 8'h5A, 1, "w31_noise");
    @(negedge clk); #1;
    check("noise_wack_count", wack_seen - ws, 1);
    @(posedge clk); #1;

    // Address extremes.
    access(1, 0, 8'h00, 8'h11, 0, "w00");
    access(1, 0, 8'hFF, 8'hFF, 0, "wFF");
    access(0, 1, 8'h00, 8'h00, 0, "r00");
    access(0, 1, 8'hFF, 8'h00, 0, "rFF");

    // Random traffic, back-to-back.
    for (int i = 0; i < 12; i++) begin
      a = 8'($urandom_range(8'h80, 8'hEF));
      d = 8'($urandom_range(0, 255));
      access(1, 1'($urandom_range(0, 1)), a, d, 0, "rnd_w");
      access(0, 1, a, 8'h00, 0, "rnd_r");
    end

    // Reset mid-write aborts it.
    access(1, 0, 8'h40, 8'h12, 0, "w40");
    access(0, 1, 8'h40, 8'h00, 0, "r40");
    @(negedge clk); ws = wack_seen; #6;
    memwrite = 1'b1; addr = 8'h40; wdata = 8'h77;
    @(posedge clk); #1;
    memwrite = 1'b0;
    @(posedge clk); #1;
    check("abort_busy_pre", {31'd0, busy}, 32'd1);
    rst = 1'b1; #1;
    check("abort_outs", {rdata, rvalid, wack, busy, err}, 32'd0);
    last_rd = 8'h00;
    @(posedge clk); #1;
    rst = 1'b0;
    access(0, 1, 8'h40, 8'h00, 0, "r40_after_rst");
    @(negedge clk); #1;
    check("abort_no_wack", wack_seen - ws, 0);
    @(posedge clk); #1;

    // Zero-wait instance: a held read completes every second cycle.
    memwrite0 = 1'b1; addr0 = 8'h55; wdata0 = 8'h9C;
    @(posedge clk); #1;
    memwrite0 = 1'b0;
    check("z_busy_w", {31'd0, busy0}, 32'd1);
    @(posedge clk); #1;
    check("z_wack", {31'd0, wack0}, 32'd1);
    memread0 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("z_busy", {31'd0, busy0}, {31'd0, (i % 2) == 0});
      check("z_rvalid", {31'd0, rvalid0}, {31'd0, (i % 2) == 1});
      check("z_err", {31'd0, err0}, 32'd0);
      if ((i % 2) == 1) check("z_rdata", {24'd0, rdata0}, 32'h9C);
    end
    memread0 = 1'b0;

    repeat (4) @(posedge clk);
    #1;
    check("sb_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL provide parameter WAIT_CYCLES, default 2, meaning extra wait states inserted before each access completes (legal range 0..15).
REQ-002 SHALL provide parameter AW, default 8, meaning address width (memory depth 2^AW bytes).
REQ-003 SHALL provide parameter DW, default 8, meaning data width (one byte per access).
REQ-004 SHALL have one clock and an asynchronous, active-high reset.
REQ-005 clk  input  1  sole clock; all state changes on the rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 memread  input  1  read request from the multicycle controller.
REQ-008 memwrite  input  1  write request from the multicycle controller.
REQ-009 addr  input  AW  byte address, selected upstream by iord.
REQ-010 wdata  input  DW  write data.
REQ-011 rdata  output  DW  read data, registered.
REQ-012 rvalid  output  1  one-cycle pulse: rdata is valid.
REQ-013 wack  output  1  one-cycle pulse: write committed.
REQ-014 busy  output  1  access in progress; new requests are ignored.
REQ-015 err  output  1  one-cycle pulse: memread and memwrite were sampled high together.

Function
REQ-016 SHALL implement the FSM states IDLE, RWAIT and WWAIT.
REQ-017 IDLE transitions:
  - memwrite=1 at edge k -> WWAIT; latch addr/wdata; load count=WAIT_CYCLES.
  - otherwise memread=1 -> RWAIT; latch addr; load count=WAIT_CYCLES.
  - otherwise remain in IDLE.
REQ-018 In RWAIT/WWAIT:
  - count>0 -> count decrements each edge.
  - count==0 -> access performed on that edge; state returns to IDLE.
REQ-019 Read completion: rdata<=mem[latched addr] and rvalid=1 for exactly the one cycle after the completing edge, i.e. the cycle after edge k+WAIT_CYCLES+1.
REQ-020 Write completion: mem[latched addr]<=latched wdata and wack=1 for exactly one cycle, with the same timing as REQ-019.
REQ-021 busy SHALL be 1 exactly while state is RWAIT or WWAIT (WAIT_CYCLES+1 cycles per access).
REQ-022 memread/memwrite/addr/wdata SHALL be ignored while busy=1; no queuing.
REQ-023 A request present in the rvalid/wack cycle SHALL be accepted (state is IDLE), giving back-to-back accesses every WAIT_CYCLES+2 cycles.
REQ-024 Simultaneous memread and memwrite in IDLE:
  - write wins.
  - err=1 for the one cycle after acceptance.
REQ-025 rdata SHALL hold its last read value until the next read completes; writes do not alter it.
REQ-026 Address arithmetic is modulo 2^AW; no out-of-range condition exists.
REQ-027 Read-after-write to the same address SHALL return the newly written data.

Reset
REQ-028 reset=1 SHALL asynchronously force:
  - state=IDLE, count=0.
  - rdata=0, rvalid=0, wack=0, busy=0, err=0.
REQ-029 Reset mid-access SHALL abort the access:
  - an aborted write leaves memory unmodified.
  - an aborted read produces no rvalid.
REQ-030 Memory array contents SHALL NOT be reset.
REQ-031 First request is accepted on the first rising edge after reset deasserts.

Structure
REQ-032 Package mem_responder_pkg SHALL hold:
  - FSM state encoding (IDLE/RWAIT/WWAIT).
  - default WAIT_CYCLES, AW and DW constants.
  - count width (4 bits).
REQ-033 Storage SHALL be one sub-module, mem_array, with synchronous write, synchronous read and 2^AW x DW entries; the FSM, counter and handshake logic stay in mem_responder.

Verification
REQ-034 WAIT_CYCLES=2: write addr=0x10, wdata=0xA5 -> busy high 3 cycles, wack pulse on 4th cycle after acceptance; then read 0x10 -> rvalid pulse with rdata=0xA5, same timing.
REQ-035 WAIT_CYCLES=0: read held high continuously -> rvalid every 2nd cycle; busy toggles 1/0.
REQ-036 memread=memwrite=1, addr=0x20, wdata=0x3C -> err pulse; write performed; subsequent read 0x20 returns 0x3C.
REQ-037 Request toggled while busy (read 0x30 during a write) -> ignored; exactly one wack and no rvalid.
REQ-038 Write 0xFF to addr=0xFF, then read 0x00 (previously written 0x11) -> 0x11; no wrap corruption.
REQ-039 Reset asserted mid-WWAIT for write 0x40<-0x77 (0x40 previously 0x12) -> all outputs 0 immediately, no wack; later read 0x40 returns 0x12.
